// File: rtl/nn_pkg.sv
// nn_pkg: definitions shared across the MNIST classifier datapath.
//   NN_DATAWIDTH   : neuron output width (signed two's complement); the
//                    neuron block uses the same value
//   NN_NUM_CLASSES : number of output-layer neurons (digit classes)
//   nn_state_e     : max_finder controller states
//   nn_signed_gt   : signed a > b on NN_DATAWIDTH-bit values
package nn_pkg;

    localparam int NN_DATAWIDTH   = 16;
    localparam int NN_NUM_CLASSES = 10;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } nn_state_e;

    // Strict compare. Ties are "not greater", which is why the lowest
    // index wins during a scan.
    function automatic logic nn_signed_gt(input logic [NN_DATAWIDTH-1:0] a,
                                          input logic [NN_DATAWIDTH-1:0] b);
        return $signed(a) > $signed(b);
    endfunction

endpackage

// File: rtl/max_finder.sv
// max_finder: arg-max over the output-layer neuron values.
// Captures all NUM_CLASSES signed values on an in_valid strobe, then scans
// them one per clock and reports the index of the largest one. Ties go to
// the lowest index.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   in_data    packed inputs; class k at [k*DATAWIDTH +: DATAWIDTH]
//   in_valid   single-cycle strobe, accepted only while busy is low
//   busy       scan in progress
//   out_class  winning index, held until the next result or reset
//   out_valid  one-cycle result strobe
//   drop_err   sticky; in_valid arrived while busy
//   out_score  winning value (only with MAX_FINDER_SCORE_EN defined)
//
// Optional feature macro: MAX_FINDER_SCORE_EN adds the out_score port.
//
// state | meaning
// IDLE  | waiting for in_valid; bank holds the previous frame
// SCAN  | comparing bank[cnt] against the running max, one per clock
module max_finder
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = NN_NUM_CLASSES,
    parameter int DATAWIDTH   = NN_DATAWIDTH,
    parameter int IDXWIDTH    = $clog2(NUM_CLASSES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CLASSES*DATAWIDTH-1:0] in_data,
    input  logic                             in_valid,
    output logic                             busy,
    output logic [IDXWIDTH-1:0]              out_class,
    output logic                             out_valid,
    output logic                             drop_err
`ifdef MAX_FINDER_SCORE_EN
    ,
    output logic [DATAWIDTH-1:0]             out_score
`endif
);

    localparam logic [IDXWIDTH-1:0] LAST_IDX = IDXWIDTH'(NUM_CLASSES - 1);

    nn_state_e             state_q, state_d;
    logic [DATAWIDTH-1:0]  bank_q [NUM_CLASSES];
    logic [DATAWIDTH-1:0]  max_q, max_d;
    logic [IDXWIDTH-1:0]   idx_q, idx_d;
    logic [IDXWIDTH-1:0]   cnt_q, cnt_d;
    logic [IDXWIDTH-1:0]   out_class_q, out_class_d;
    logic                  out_valid_q, out_valid_d;
    logic                  drop_err_q, drop_err_d;
    logic                  capture;
    logic [DATAWIDTH-1:0]  cand;
    logic                  win;
`ifdef MAX_FINDER_SCORE_EN
    logic [DATAWIDTH-1:0]  score_q, score_d;
`endif

    assign cand = bank_q[cnt_q];
    assign win  = nn_signed_gt(cand, max_q);

    always_comb begin
        state_d     = state_q;
        max_d       = max_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_class_d = out_class_q;
        out_valid_d = 1'b0;
        drop_err_d  = drop_err_q;
        capture     = 1'b0;
`ifdef MAX_FINDER_SCORE_EN
        score_d     = score_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Element 0 seeds the running max directly from the
                    // input so the scan starts at element 1.
                    capture = 1'b1;
                    max_d   = in_data[DATAWIDTH-1:0];
                    idx_d   = '0;
                    cnt_d   = IDXWIDTH'(1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (in_valid) begin
                    drop_err_d = 1'b1;
                end
                if (win) begin
                    max_d = cand;
                    idx_d = cnt_q;
                end
                if (cnt_q == LAST_IDX) begin
                    // The last element's compare resolves in the same
                    // cycle the result is registered.
                    out_class_d = win ? cnt_q : idx_q;
`ifdef MAX_FINDER_SCORE_EN
                    score_d     = win ? cand : max_q;
`endif
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            max_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_class_q <= '0;
            out_valid_q <= 1'b0;
            drop_err_q  <= 1'b0;
`ifdef MAX_FINDER_SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_class_q <= out_class_d;
            out_valid_q <= out_valid_d;
            drop_err_q  <= drop_err_d;
`ifdef MAX_FINDER_SCORE_EN
            score_q     <= score_d;
`endif
        end
    end

    // Written only on an accepted strobe, so in_data is free to change
    // while a scan is running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                bank_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                bank_q[k] <= in_data[k*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    assign busy      = (state_q == SCAN);
    assign out_class = out_class_q;
    assign out_valid = out_valid_q;
    assign drop_err  = drop_err_q;
`ifdef MAX_FINDER_SCORE_EN
    assign out_score = score_q;
`endif

endmodule

// File: tb/tb_max_finder.sv
// Self-checking bench for max_finder with default parameters.
module tb_max_finder;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int LAT = N - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N*DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          busy;
    logic [3:0]    out_class;
    logic          out_valid;
    logic          drop_err;
`ifdef MAX_FINDER_SCORE_EN
    logic [DW-1:0] out_score;
`endif

    int total = 0;
    int bad   = 0;

    max_finder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .busy      (busy),
        .out_class (out_class),
        .out_valid (out_valid),
        .drop_err  (drop_err)
`ifdef MAX_FINDER_SCORE_EN
        ,
        .out_score (out_score)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] pack(input int v[N]);
        logic [N*DW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = v[k][DW-1:0];
        return r;
    endfunction

    // Reference: first index holding the largest signed value.
    function automatic int ref_idx(input logic [N*DW-1:0] d);
        int best;
        int bv;
        int v;
        best = 0;
        bv   = int'($signed(d[DW-1:0]));
        for (int k = 1; k < N; k++) begin
            v = int'($signed(d[k*DW +: DW]));
            if (v > bv) begin
                bv   = v;
                best = k;
            end
        end
        return best;
    endfunction

    function automatic logic [N*DW-1:0] rand_frame();
        logic [N*DW-1:0] r;
        int sel;
        for (int k = 0; k < N; k++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       r[k*DW +: DW] = 16'h8000;
                1:       r[k*DW +: DW] = 16'h7fff;
                2, 3:    r[k*DW +: DW] = DW'($urandom);
                default: r[k*DW +: DW] = DW'(int'($urandom_range(0, 8)) - 4);
            endcase
        end
        return r;
    endfunction

    // Called #1 after a rising edge. Presents d with in_valid, then waits
    // for the result. drop_at > 0 raises in_valid again (other data) in
    // that cycle after capture; scramble changes in_data every cycle.
    task automatic run_frame(input logic [N*DW-1:0] d, input int drop_at, input bit scramble,
                             output int lat, output int cls, output int busy_cyc,
                             output logic [DW-1:0] score);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = -1;
        busy_cyc = 0;
        for (int e = 1; e <= 20; e++) begin
            if (busy) busy_cyc++;
            in_valid = 1'b0;
            if (scramble) in_data = rand_frame();
            if (e == drop_at) begin
                in_valid = 1'b1;
                in_data  = rand_frame();
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        in_valid = 1'b0;
        cls      = int'(out_class);
`ifdef MAX_FINDER_SCORE_EN
        score = out_score;
`else
        score = '0;
`endif
    endtask

    int lat, cls, bc, r;
    logic [DW-1:0] sc;
    logic [N*DW-1:0] d, d2;
    int v[N];

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_class", out_class, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_drop", drop_err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        v = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};
        d = pack(v);
        run_frame(d, 0, 1'b0, lat, cls, bc, sc);
        chk("a_lat", lat, LAT);
        chk("a_class", cls, 2);
        chk("a_busy", bc, LAT);
`ifdef MAX_FINDER_SCORE_EN
        chk("a_score", sc, 7);
`endif
        @(posedge clk);
        #1;
        chk("a_pulse1", out_valid, 0);
        chk("a_hold", out_class, 2);

        v = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32767};
        run_frame(pack(v), 0, 1'b0, lat, cls, bc, sc);
        chk("min_class", cls, 9);
        v = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        run_frame(pack(v), 0, 1'b0, lat, cls, bc, sc);
        chk("eq_class", cls, 0);

        // back-to-back: second strobe lands in the out_valid cycle
        v = '{100, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        d = pack(v);
        v = '{0, 1, 2, 3, 4, 5, 6, 7, 99, 9};
        d2 = pack(v);
        run_frame(d, 0, 1'b0, lat, cls, bc, sc);
        chk("b2b_cls0", cls, 0);
        chk("b2b_lat0", lat, LAT);
        run_frame(d2, 0, 1'b0, lat, cls, bc, sc);
        chk("b2b_cls1", cls, 8);
        chk("b2b_lat1", lat, LAT);
        chk("b2b_drop", drop_err, 0);

        // randomized frames, some with in_data churning during the scan
        for (int i = 0; i < 40; i++) begin
            d = rand_frame();
            r = ref_idx(d);
            run_frame(d, 0, (i % 2) == 1, lat, cls, bc, sc);
            chk("rnd_lat", lat, LAT);
            chk("rnd_class", cls, r);
`ifdef MAX_FINDER_SCORE_EN
            chk("rnd_score", sc, 32'(d[r*DW +: DW]));
`endif
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        // strobe while busy is dropped and flagged
        v = '{1, 2, 3, 50, 4, 5, 6, 7, 8, 9};
        run_frame(pack(v), 3, 1'b0, lat, cls, bc, sc);
        chk("drop_lat", lat, LAT);
        chk("drop_class", cls, 3);
        chk("drop_flag", drop_err, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("drop_novalid", out_valid, 0);
        v = '{1, 2, 3, 4, 5, 6, 70, 7, 8, 9};
        run_frame(pack(v), 0, 1'b0, lat, cls, bc, sc);
        chk("drop_next", cls, 6);
        chk("drop_sticky", drop_err, 1);

        // reset in the middle of a scan
        v = '{1, 2, 3, 4, 5, 6, 7, 80, 8, 9};
        in_data  = pack(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_class", out_class, 0);
        chk("mid_drop", drop_err, 0);
        @(negedge clk);
        rst = 1'b1;
        r = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) r++;
        end
        chk("mid_nopulse", r, 0);
        chk("mid_class2", out_class, 0);
        chk("mid_busy2", busy, 0);
        v = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 90};
        run_frame(pack(v), 0, 1'b0, lat, cls, bc, sc);
        chk("post_lat", lat, LAT);
        chk("post_class", cls, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
